// File: rtl/mpdec_pkg.sv
// Shared types and constants for the multi-phase divider bus checker.
package mpdec_pkg;
   typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;
   localparam int         MP_W       = 8;
   localparam logic [9:1] LFSR_SEED  = 9'd1;
   localparam int         LFSR_TAP_A = 9;
   localparam int         LFSR_TAP_B = 5;
endpackage

// File: rtl/mpdec_lfsr9.sv
// 9-bit XNOR LFSR reproducing the divider's dither sequence; advances on i_adv.
module mpdec_lfsr9
   import mpdec_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_adv,
   output logic [9:1] o_state
);
   logic [9:1] r_l;
   logic       w_fb;

   assign w_fb    = ~(r_l[LFSR_TAP_A] ^ r_l[LFSR_TAP_B]);
   assign o_state = r_l;

   always_ff @(posedge i_clk) begin
      if (i_rst)      r_l <= LFSR_SEED;
      else if (i_adv) r_l <= {r_l[8:1], w_fb};
   end
endmodule

// File: rtl/mp_phase_decoder.sv
// Receive-side checker for the 8-phase interleaved divider bus: decode, sequence lock, slip/error count.
// Optional dither-sequence checker enabled by defining MPDEC_LFSR_CHK_EN.
module mp_phase_decoder
   import mpdec_pkg::*;
#(
   parameter int LOCK_N   = 8,
   parameter int UNLOCK_N = 4,
   parameter int ERRW     = 16
)(
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_en,
   input  logic [MP_W-1:0] i_mp,
   input  logic            i_err_clr,
`ifdef MPDEC_LFSR_CHK_EN
   input  logic            i_urn_stb,
   input  logic [5:0]      i_urn6b,
   output logic            o_lfsr_err,
`endif
   output logic [2:0]      o_phase,
   output logic            o_phase_vld,
   output logic            o_lock,
   output logic            o_slip,
   output logic [ERRW-1:0] o_err_cnt
);
   localparam int GW = $clog2(LOCK_N + 1);
   localparam int BW = $clog2(UNLOCK_N + 1);

   logic [MP_W-1:0] r_mp_q;
   state_t          r_state, w_state_nx;
   logic [GW-1:0]   r_good_cnt, w_good_nx;
   logic [BW-1:0]   r_bad_cnt, w_bad_nx;
   logic [2:0]      r_phase, w_phase_nx;
   logic [2:0]      r_exp, w_exp_nx;
   logic            r_vld, w_vld_nx;
   logic            r_slip, w_slip_nx;
   logic            w_errinc;
   logic [ERRW-1:0] r_err;

   logic [3:0]      w_pop, w_nstart;
   logic [2:0]      w_s, w_dec;
   logic            w_legal, w_good;

   // A legal word is one contiguous circular run of four ones; its rising edge s locates the count.
   always_comb begin
      w_pop    = '0;
      w_nstart = '0;
      w_s      = '0;
      for (int i = 0; i < MP_W; i++) begin
         w_pop = w_pop + 4'(r_mp_q[i]);
         if (r_mp_q[i] && !r_mp_q[(i + MP_W - 1) % MP_W]) begin
            w_nstart = w_nstart + 4'd1;
            w_s      = 3'(i);
         end
      end
   end

   assign w_legal = (w_pop == 4'd4) && (w_nstart == 4'd1);
   assign w_dec   = w_s + 3'd3;
   assign w_good  = w_legal && (w_dec == r_exp);

   always_comb begin
      w_state_nx = r_state;
      w_good_nx  = r_good_cnt;
      w_bad_nx   = r_bad_cnt;
      w_phase_nx = w_legal ? w_dec : r_phase;
      w_vld_nx   = w_legal;
      w_exp_nx   = w_legal ? w_dec + 3'd1 : r_exp + 3'd1;
      w_slip_nx  = 1'b0;
      w_errinc   = 1'b0;
      if (!i_en) begin
         w_state_nx = SEARCH;
         w_good_nx  = '0;
         w_bad_nx   = '0;
         w_phase_nx = r_phase;
         w_vld_nx   = 1'b0;
      end else begin
         unique case (r_state)
            SEARCH: begin
               if (w_legal) begin
                  w_state_nx = TRACK;
                  w_good_nx  = GW'(1);
               end
            end
            TRACK: begin
               if (w_good) begin
                  if (r_good_cnt + GW'(1) == GW'(LOCK_N)) begin
                     w_state_nx = LOCKED;
                     w_good_nx  = '0;
                  end else begin
                     w_good_nx  = r_good_cnt + GW'(1);
                  end
               end else begin
                  w_state_nx = SEARCH;
                  w_good_nx  = '0;
               end
            end
            LOCKED: begin
               if (w_good) begin
                  w_bad_nx = '0;
               end else begin
                  w_errinc  = 1'b1;
                  w_slip_nx = w_legal;
                  if (r_bad_cnt + BW'(1) == BW'(UNLOCK_N)) begin
                     w_state_nx = SEARCH;
                     w_bad_nx   = '0;
                  end else begin
                     w_bad_nx   = r_bad_cnt + BW'(1);
                  end
               end
            end
            default: w_state_nx = SEARCH;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mp_q     <= '0;
         r_state    <= SEARCH;
         r_good_cnt <= '0;
         r_bad_cnt  <= '0;
         r_phase    <= '0;
         r_exp      <= '0;
         r_vld      <= 1'b0;
         r_slip     <= 1'b0;
         r_err      <= '0;
      end else begin
         r_mp_q     <= i_mp;
         r_state    <= w_state_nx;
         r_good_cnt <= w_good_nx;
         r_bad_cnt  <= w_bad_nx;
         r_phase    <= w_phase_nx;
         r_exp      <= w_exp_nx;
         r_vld      <= w_vld_nx;
         r_slip     <= w_slip_nx;
         if (i_err_clr)                     r_err <= '0;
         else if (w_errinc && r_err != '1)  r_err <= r_err + ERRW'(1);
      end
   end

   assign o_phase     = r_phase;
   assign o_phase_vld = r_vld;
   assign o_lock      = (r_state == LOCKED);
   assign o_slip      = r_slip;
   assign o_err_cnt   = r_err;

`ifdef MPDEC_LFSR_CHK_EN
   logic [9:1] w_lfsr;
   logic       r_lfsr_err;

   // Disabling the decoder restarts the dither sequence from the seed.
   mpdec_lfsr9 u_lfsr (
      .i_clk   (i_clk),
      .i_rst   (i_rst | ~i_en),
      .i_adv   (i_urn_stb & i_en),
      .o_state (w_lfsr)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) r_lfsr_err <= 1'b0;
      else       r_lfsr_err <= i_en && i_urn_stb && (i_urn6b != w_lfsr[6:1]);
   end

   assign o_lfsr_err = r_lfsr_err;
`endif
endmodule
